// File: rtl/spm_serializer.sv
// Parallel-to-serial operand feeder for the SPM carry-save array: LSB first, OUT_CYCLES bits per word.
// Optional macro SIGN_EXT_EN: fill bits past WIDTH repeat the operand's sign bit instead of zero.
module spm_serializer #(
   parameter int WIDTH      = 8,
   parameter int OUT_CYCLES = 2 * WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] x_par,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             bit_out,
   output logic             bit_valid,
   input  logic             bit_ready,
   output logic             busy,
   output logic             done
);

   localparam int            CW   = $clog2(OUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(OUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sreg;
   logic [CW-1:0]    cnt;
   logic             fill;
   logic [WIDTH-1:0] sreg_next;

   // Handshakes: a word moves on load_valid && load_ready, a bit moves on bit_valid && bit_ready,
   // both at the rising edge; the holder keeps its data stable until that edge.
   assign load_ready = (state == IDLE);
   assign sreg_next  = {fill, sreg[WIDTH-1:1]};

`ifdef SIGN_EXT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         fill <= 1'b0;
      end else if (state == IDLE && load_valid) begin
         fill <= x_par[WIDTH-1];
      end
   end
`else
   assign fill = 1'b0;
`endif

   // bit_out is kept equal to sreg[0] while in SHIFT by loading it with the next LSB ahead of time.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         sreg      <= '0;
         cnt       <= '0;
         bit_out   <= 1'b0;
         bit_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (load_valid) begin
                  state     <= SHIFT;
                  sreg      <= x_par;
                  cnt       <= '0;
                  bit_out   <= x_par[0];
                  bit_valid <= 1'b1;
                  busy      <= 1'b1;
                  done      <= 1'b0;
               end
            end
            SHIFT: begin
               if (bit_ready) begin
                  sreg <= sreg_next;
                  cnt  <= cnt + CW'(1);
                  if (cnt == LAST) begin
                     state     <= DONE;
                     bit_out   <= 1'b0;
                     bit_valid <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     bit_out <= sreg_next[0];
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               bit_out   <= 1'b0;
               bit_valid <= 1'b0;
               busy      <= 1'b0;
               done      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spm_serializer.sv
// Bench for spm_serializer: directed vector table, reset corner cases, and randomized words
// with random back-pressure checked against a bit-list model of the serial stream.
module tb_spm_serializer;

   localparam int WIDTH      = 8;
   localparam int OUT_CYCLES = 16;

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] x_par;
   logic             load_valid;
   logic             load_ready;
   logic             bit_out;
   logic             bit_valid;
   logic             bit_ready;
   logic             busy;
   logic             done;

   int checks = 0;
   int errors = 0;

   spm_serializer #(.WIDTH(WIDTH), .OUT_CYCLES(OUT_CYCLES)) dut (
      .clk        (clk),
      .rst        (rst),
      .x_par      (x_par),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .bit_out    (bit_out),
      .bit_valid  (bit_valid),
      .bit_ready  (bit_ready),
      .busy       (busy),
      .done       (done)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  x;
      int          stall_after;
      int          stall_len;
      logic [15:0] exp_u;
      logic [15:0] exp_s;
      int          exp_done;
      bit          hold;
      logic [7:0]  next_x;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: the first WIDTH bits are the operand LSB first, the rest are the fill bit.
   function automatic logic [15:0] model_stream(input logic [7:0] x);
      logic        f;
      logic [15:0] r;
`ifdef SIGN_EXT_EN
      f = x[WIDTH-1];
`else
      f = 1'b0;
`endif
      r = '0;
      for (int i = 0; i < OUT_CYCLES; i++) r[i] = (i < WIDTH) ? x[i] : f;
      return r;
   endfunction

   // Protocol invariants sampled every cycle away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         checks++;
         if (bit_valid && (done || load_ready)) begin
            errors++;
            $display("FAIL invariant bit_valid=%0b done=%0b load_ready=%0b at %0t",
                     bit_valid, done, load_ready, $time);
         end
      end
   end

   // ---------------- driver + scoreboard ----------------
   task automatic run_word(input logic [7:0] x, input int stall_after, input int stall_len,
                           input bit rnd, input logic [15:0] exp_word, input int exp_done,
                           input bit hold, input logic [7:0] next_x);
      logic exp_q[$];
      int   cyc, popped, stalls, stall_left, n;
      exp_q.delete();
      for (int i = 0; i < OUT_CYCLES; i++) exp_q.push_back(exp_word[i]);
      n = 0;
      while (!load_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("load_ready_wait", load_ready, 1);
      load_valid = 1'b1;
      x_par      = x;
      bit_ready  = 1'b1;
      cyc = 0; popped = 0; stalls = 0; stall_left = stall_len;
      while (exp_q.size() != 0 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (hold) begin
            load_valid = 1'b1;
            x_par      = next_x;
         end else begin
            load_valid = 1'($urandom_range(0, 1));
            x_par      = 8'($urandom);
         end
         check("stream_bit_valid", bit_valid, 1);
         check("stream_busy", busy, 1);
         check("stream_load_ready", load_ready, 0);
         check("stream_done", done, 0);
         if (bit_valid) check($sformatf("bit_out[%0d]", popped), bit_out, exp_q[0]);
         if (rnd) begin
            bit_ready = ($urandom_range(0, 3) != 0);
         end else if (popped == stall_after && stall_left > 0) begin
            bit_ready = 1'b0;
            stall_left--;
         end else begin
            bit_ready = 1'b1;
         end
         if (bit_valid && bit_ready) begin
            void'(exp_q.pop_front());
            popped++;
         end else begin
            stalls++;
         end
      end
      check("stream_timeout", exp_q.size(), 0);
      @(negedge clk);
      cyc++;
      if (!hold) load_valid = 1'b0;
      check("done_pulse", done, 1);
      check("done_bit_valid", bit_valid, 0);
      check("done_bit_out", bit_out, 0);
      check("done_busy", busy, 1);
      check("done_load_ready", load_ready, 0);
      check("done_cycle", cyc, (exp_done < 0) ? (OUT_CYCLES + 1 + stalls) : exp_done);
      bit_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("idle_load_ready", load_ready, 1);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_bit_valid", bit_valid, 0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      vecs[0] = '{8'hA5, 0,  0, 16'h00A5, 16'hFFA5, 17, 1'b0, 8'h00};
      vecs[1] = '{8'h35, 0,  0, 16'h0035, 16'h0035, 17, 1'b0, 8'h00};
      vecs[2] = '{8'hA5, 4,  3, 16'h00A5, 16'hFFA5, 20, 1'b0, 8'h00};
      vecs[3] = '{8'h80, 15, 2, 16'h0080, 16'hFF80, 19, 1'b0, 8'h00};
      vecs[4] = '{8'h7F, 0,  5, 16'h007F, 16'h007F, 22, 1'b0, 8'h00};
      vecs[5] = '{8'hFF, 0,  0, 16'h00FF, 16'hFFFF, 17, 1'b1, 8'h0F};
      vecs[6] = '{8'h0F, 0,  0, 16'h000F, 16'h000F, 17, 1'b0, 8'h00};

      rst = 1'b1; load_valid = 1'b0; x_par = '0; bit_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_load_ready", load_ready, 1);
      check("rst_bit_out", bit_out, 0);
      check("rst_bit_valid", bit_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      rst = 1'b0;
      @(negedge clk);

      for (int v = 0; v < 7; v++) begin
`ifdef SIGN_EXT_EN
         run_word(vecs[v].x, vecs[v].stall_after, vecs[v].stall_len, 1'b0, vecs[v].exp_s,
                  vecs[v].exp_done, vecs[v].hold, vecs[v].next_x);
`else
         run_word(vecs[v].x, vecs[v].stall_after, vecs[v].stall_len, 1'b0, vecs[v].exp_u,
                  vecs[v].exp_done, vecs[v].hold, vecs[v].next_x);
`endif
      end

      // Reset in the middle of a stream abandons it without a done pulse.
      load_valid = 1'b1; x_par = 8'hA5; bit_ready = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         load_valid = 1'b0;
      end
      check("mid_bit5_valid", bit_valid, 1);
      check("mid_bit5_value", bit_out, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_bit_valid", bit_valid, 0);
      check("mid_rst_load_ready", load_ready, 1);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      repeat (3) begin
         @(negedge clk);
         check("post_rst_done", done, 0);
         check("post_rst_idle", load_ready, 1);
      end
      run_word(8'h01, 0, 0, 1'b0, 16'h0001, 17, 1'b0, 8'h00);

      // Reset together with an offered word: the word must not be taken.
      rst = 1'b1; load_valid = 1'b1; x_par = 8'hFF;
      @(negedge clk);
      rst = 1'b0; load_valid = 1'b0;
      check("rst_load_ready_hold", load_ready, 1);
      check("rst_load_bit_valid", bit_valid, 0);
      check("rst_load_busy", busy, 0);
      @(negedge clk);
      check("rst_load_still_idle", bit_valid, 0);

      for (int r = 0; r < 20; r++) begin
         logic [7:0] rx;
         rx = 8'($urandom);
         run_word(rx, 0, 0, 1'b1, model_stream(rx), -1, 1'b0, 8'h00);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
